coffee_vend_ctrl: RTL and testbench

Parametrised vending controller for the coffee machine. It generalises the fixed 2.0-credit, three-product controller: per-product prices, N products, a credit ceiling, cancel with coin refund, change return and a timed dispense strobe. It sits between the coin acceptor and selection keypad on one side, and the brew and coin-return actuators on the other.

---
 rtl/coffee_vend_ctrl.sv | 158 +++++++++++++++
 tb/tb_coffee_vend_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/coffee_vend_ctrl.sv
// Coffee machine vending controller: coin credit, per-product prices, cancel
// with refund, timed one-hot brew strobe and change return, all outputs registered.
module coffee_vend_ctrl #(
    parameter int                         N_PROD      = 3,
    parameter int                         CREDIT_W    = 5,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = {5'd6, 5'd4, 5'd4},
    parameter int                         MAX_CREDIT  = 8,
    parameter int                         DISP_CYCLES = 3,
    parameter int                         SEL_W       = $clog2(N_PROD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                credit05,
    input  logic                credit10,
    input  logic [SEL_W-1:0]    coffee,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_PROD-1:0]   dispense,
    output logic                change05,
    output logic                coin_reject,
    output logic                busy,
    output logic [1:0]          current_state
);

    localparam int                CNT_W    = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DISP_CYCLES - 1);
    localparam logic [CREDIT_W:0] MAX_CR   = (CREDIT_W + 1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [N_PROD-1:0]   dispense_n;
    logic                change05_n;
    logic                coin_reject_n;
    logic                busy_n;
    logic [CNT_W-1:0]    disp_cnt, disp_cnt_n;

    logic [CREDIT_W-1:0] sel_price;
    logic [N_PROD-1:0]   sel_onehot;
    logic                sel_ok;
    logic                coin_any;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;

    // Selection decode; codes 0 and above N_PROD never match a product.
    always_comb begin
        sel_price  = '0;
        sel_onehot = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (coffee == SEL_W'(i + 1)) begin
                sel_price     = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_onehot[i] = 1'b1;
            end
        end
        sel_ok = (sel_onehot != '0) && (credit >= sel_price);
    end

    // Coin value: credit10 wins when both coins arrive together.
    always_comb begin
        coin_any  = credit05 | credit10;
        coin_val  = credit10 ? (CREDIT_W + 1)'(2) : {{CREDIT_W{1'b0}}, credit05};
        coin_sum  = {1'b0, credit} + coin_val;
        coin_fits = (coin_sum <= MAX_CR);
    end

    always_comb begin
        state_n       = state;
        credit_n      = credit;
        dispense_n    = dispense;
        change05_n    = 1'b0;
        coin_reject_n = 1'b0;
        disp_cnt_n    = disp_cnt;

        case (state)
            S_IDLE, S_CREDIT: begin
                if (cancel && (credit != '0)) begin
                    state_n       = S_CHANGE;
                    change05_n    = 1'b1;
                    coin_reject_n = coin_any;
                end else if (sel_ok) begin
                    state_n       = S_DISPENSE;
                    credit_n      = credit - sel_price;
                    dispense_n    = sel_onehot;
                    disp_cnt_n    = CNT_LAST;
                    coin_reject_n = coin_any;
                end else begin
                    if (coin_any && coin_fits) begin
                        credit_n = coin_sum[CREDIT_W-1:0];
                    end
                    coin_reject_n = (credit05 && credit10) || (coin_any && !coin_fits);
                    state_n       = (credit_n != '0) ? S_CREDIT : S_IDLE;
                end
            end
            S_DISPENSE: begin
                coin_reject_n = coin_any;
                if (disp_cnt == '0) begin
                    dispense_n = '0;
                    if (credit != '0) begin
                        state_n    = S_CHANGE;
                        change05_n = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    disp_cnt_n = disp_cnt - CNT_W'(1);
                end
            end
            S_CHANGE: begin
                // Credit shows the units still owed, including the one ejected this cycle.
                coin_reject_n = coin_any;
                if (credit > CREDIT_W'(1)) begin
                    credit_n   = credit - CREDIT_W'(1);
                    change05_n = 1'b1;
                end else begin
                    credit_n = '0;
                    state_n  = S_IDLE;
                end
            end
            default: begin
                state_n    = S_IDLE;
                credit_n   = '0;
                dispense_n = '0;
            end
        endcase

        busy_n = (state_n == S_DISPENSE) || (state_n == S_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            credit      <= '0;
            dispense    <= '0;
            change05    <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
            disp_cnt    <= '0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            dispense    <= dispense_n;
            change05    <= change05_n;
            coin_reject <= coin_reject_n;
            busy        <= busy_n;
            disp_cnt    <= disp_cnt_n;
        end
    end

    assign current_state = state;

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Directed bench for coffee_vend_ctrl: default 3-product instance plus a
// 5-product, 1-cycle-strobe instance, checked with immediate assertions.
module tb_coffee_vend_ctrl;

    logic       clk = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         pulses;

    logic       a_rst, a_c05, a_c10, a_cancel;
    logic [1:0] a_coffee;
    logic [4:0] a_credit;
    logic [2:0] a_dispense;
    logic       a_change05, a_coin_reject, a_busy;
    logic [1:0] a_state;

    logic       b_rst, b_c05, b_c10, b_cancel;
    logic [2:0] b_coffee;
    logic [4:0] b_credit;
    logic [4:0] b_dispense;
    logic       b_change05, b_coin_reject, b_busy;
    logic [1:0] b_state;

    always #5 clk = ~clk;

    coffee_vend_ctrl dut (
        .clk(clk), .rst(a_rst), .credit05(a_c05), .credit10(a_c10),
        .coffee(a_coffee), .cancel(a_cancel), .credit(a_credit),
        .dispense(a_dispense), .change05(a_change05), .coin_reject(a_coin_reject),
        .busy(a_busy), .current_state(a_state)
    );

    coffee_vend_ctrl #(
        .N_PROD(5), .CREDIT_W(5),
        .PRICES({5'd5, 5'd4, 5'd3, 5'd2, 5'd1}),
        .MAX_CREDIT(8), .DISP_CYCLES(1)
    ) dut5 (
        .clk(clk), .rst(b_rst), .credit05(b_c05), .credit10(b_c10),
        .coffee(b_coffee), .cancel(b_cancel), .credit(b_credit),
        .dispense(b_dispense), .change05(b_change05), .coin_reject(b_coin_reject),
        .busy(b_busy), .current_state(b_state)
    );

    task automatic apply_stimulus(input logic c05, input logic c10,
                                  input logic [1:0] sel, input logic can);
        a_c05 = c05; a_c10 = c10; a_coffee = sel; a_cancel = can;
        @(posedge clk);
        #1;
        a_c05 = 1'b0; a_c10 = 1'b0; a_coffee = 2'd0; a_cancel = 1'b0;
    endtask

    task automatic apply_stimulus_b(input logic c05, input logic c10,
                                    input logic [2:0] sel, input logic can);
        b_c05 = c05; b_c10 = c10; b_coffee = sel; b_cancel = can;
        @(posedge clk);
        #1;
        b_c05 = 1'b0; b_c10 = 1'b0; b_coffee = 3'd0; b_cancel = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_c05 = 1'b0; a_c10 = 1'b0; a_coffee = 2'd0; a_cancel = 1'b0;
        b_rst = 1'b1; b_c05 = 1'b0; b_c10 = 1'b0; b_coffee = 3'd0; b_cancel = 1'b0;
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2'd1, 1'b1);
        check_output("rst_credit", 32'(a_credit), 0);
        check_output("rst_dispense", 32'(a_dispense), 0);
        check_output("rst_change05", 32'(a_change05), 0);
        check_output("rst_coin_reject", 32'(a_coin_reject), 0);
        check_output("rst_busy", 32'(a_busy), 0);
        check_output("rst_state", 32'(a_state), 0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        $display("[TB] exact price, no change");
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        check_output("t1_credit_2", 32'(a_credit), 2);
        check_output("t1_state_credit", 32'(a_state), 1);
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        check_output("t1_credit_4", 32'(a_credit), 4);
        apply_stimulus(1'b0, 1'b0, 2'd1, 1'b0);
        check_output("t1_credit_0", 32'(a_credit), 0);
        check_output("t1_dispense_c1", 32'(a_dispense), 1);
        check_output("t1_busy_c1", 32'(a_busy), 1);
        check_output("t1_state_disp", 32'(a_state), 2);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t1_dispense_c2", 32'(a_dispense), 1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t1_dispense_c3", 32'(a_dispense), 1);
        check_output("t1_busy_c3", 32'(a_busy), 1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t1_dispense_end", 32'(a_dispense), 0);
        check_output("t1_change05", 32'(a_change05), 0);
        check_output("t1_busy_end", 32'(a_busy), 0);
        check_output("t1_state_idle", 32'(a_state), 0);

        $display("[TB] dispense with change");
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        check_output("t2_credit_5", 32'(a_credit), 5);
        apply_stimulus(1'b0, 1'b0, 2'd2, 1'b0);
        check_output("t2_dispense", 32'(a_dispense), 2);
        check_output("t2_credit_1", 32'(a_credit), 1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t2_dispense_c3", 32'(a_dispense), 2);
        check_output("t2_no_change_yet", 32'(a_change05), 0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t2_dispense_end", 32'(a_dispense), 0);
        check_output("t2_change05", 32'(a_change05), 1);
        check_output("t2_state_change", 32'(a_state), 3);
        check_output("t2_busy_change", 32'(a_busy), 1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t2_change05_off", 32'(a_change05), 0);
        check_output("t2_credit_0", 32'(a_credit), 0);
        check_output("t2_state_idle", 32'(a_state), 0);

        $display("[TB] credit ceiling and cancel refund");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        check_output("t3_credit_8", 32'(a_credit), 8);
        check_output("t3_no_reject", 32'(a_coin_reject), 0);
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        check_output("t3_over_reject", 32'(a_coin_reject), 1);
        check_output("t3_over_credit", 32'(a_credit), 8);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
        check_output("t3_cancel_state", 32'(a_state), 3);
        check_output("t3_cancel_reject_off", 32'(a_coin_reject), 0);
        pulses = 32'(a_change05);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
            pulses += 32'(a_change05);
        end
        check_output("t3_refund_pulses", 32'(pulses), 8);
        check_output("t3_refund_credit", 32'(a_credit), 0);

        $display("[TB] insufficient credit, cancel beats selection");
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd3, 1'b0);
        check_output("t4_ignored_state", 32'(a_state), 1);
        check_output("t4_ignored_credit", 32'(a_credit), 4);
        check_output("t4_ignored_dispense", 32'(a_dispense), 0);
        apply_stimulus(1'b1, 1'b0, 2'd1, 1'b1);
        check_output("t4_cancel_state", 32'(a_state), 3);
        check_output("t4_cancel_dispense", 32'(a_dispense), 0);
        check_output("t4_cancel_coin_reject", 32'(a_coin_reject), 1);
        check_output("t4_cancel_credit", 32'(a_credit), 4);
        pulses = 32'(a_change05);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
            pulses += 32'(a_change05);
        end
        check_output("t4_refund_pulses", 32'(pulses), 4);
        check_output("t4_refund_credit", 32'(a_credit), 0);
        check_output("t4_refund_state", 32'(a_state), 0);

        $display("[TB] both coins together, coins while busy");
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2'd0, 1'b0);
        check_output("t3_both_credit", 32'(a_credit), 6);
        check_output("t3_both_reject", 32'(a_coin_reject), 1);
        apply_stimulus(1'b0, 1'b0, 2'd1, 1'b0);
        check_output("t5_sel_credit", 32'(a_credit), 2);
        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        check_output("t5_disp_reject", 32'(a_coin_reject), 1);
        check_output("t5_disp_credit", 32'(a_credit), 2);
        check_output("t5_disp_dispense", 32'(a_dispense), 1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t5_chg_enter", 32'(a_change05), 1);
        check_output("t5_chg_credit2", 32'(a_credit), 2);
        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        check_output("t5_chg_reject", 32'(a_coin_reject), 1);
        check_output("t5_chg_credit1", 32'(a_credit), 1);
        check_output("t5_chg_pulse2", 32'(a_change05), 1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t5_chg_done_credit", 32'(a_credit), 0);
        check_output("t5_chg_done_state", 32'(a_state), 0);
        check_output("t5_chg_done_pulse", 32'(a_change05), 0);

        $display("[TB] reset mid-dispense");
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd1, 1'b0);
        check_output("t6_pending_credit", 32'(a_credit), 1);
        a_rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t6_rst_dispense", 32'(a_dispense), 0);
        check_output("t6_rst_credit", 32'(a_credit), 0);
        check_output("t6_rst_state", 32'(a_state), 0);
        check_output("t6_rst_busy", 32'(a_busy), 0);
        check_output("t6_rst_change05", 32'(a_change05), 0);
        a_rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);
        check_output("t6_after_change05", 32'(a_change05), 0);
        check_output("t6_after_state", 32'(a_state), 0);

        $display("[TB] five products, one-cycle strobe");
        apply_stimulus_b(1'b0, 1'b1, 3'd0, 1'b0);
        check_output("b_credit_2", 32'(b_credit), 2);
        apply_stimulus_b(1'b0, 1'b0, 3'd6, 1'b0);
        check_output("b_code6_state", 32'(b_state), 1);
        check_output("b_code6_dispense", 32'(b_dispense), 0);
        apply_stimulus_b(1'b0, 1'b0, 3'd5, 1'b0);
        check_output("b_short_credit", 32'(b_credit), 2);
        apply_stimulus_b(1'b0, 1'b0, 3'd2, 1'b0);
        check_output("b_sel2_dispense", 32'(b_dispense), 2);
        check_output("b_sel2_credit", 32'(b_credit), 0);
        apply_stimulus_b(1'b0, 1'b0, 3'd0, 1'b0);
        check_output("b_strobe_end", 32'(b_dispense), 0);
        check_output("b_strobe_state", 32'(b_state), 0);
        for (int i = 0; i < 3; i++) apply_stimulus_b(1'b0, 1'b1, 3'd0, 1'b0);
        apply_stimulus_b(1'b0, 1'b0, 3'd5, 1'b0);
        check_output("b_sel5_dispense", 32'(b_dispense), 16);
        check_output("b_sel5_credit", 32'(b_credit), 1);
        apply_stimulus_b(1'b0, 1'b0, 3'd0, 1'b0);
        check_output("b_sel5_change", 32'(b_change05), 1);
        check_output("b_sel5_disp_off", 32'(b_dispense), 0);
        apply_stimulus_b(1'b0, 1'b0, 3'd0, 1'b0);
        check_output("b_final_state", 32'(b_state), 0);
        check_output("b_final_credit", 32'(b_credit), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
